// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares one BRAM port-b between a load/store unit (r0) and a
//               debug/loader port (r1); also sequences a memory clear via rstb.
//               Optional macro ARB_ROUND_ROBIN_EN selects round-robin on
//               contention (default: fixed priority, r0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter #(
    parameter logic [31:0] ADDR_BASE    = 32'h00000600,
    parameter logic [31:0] ADDR_SPAN    = 32'd26624,
    parameter logic [7:0]  CLEAR_CYCLES = 8'd4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        r0_req_i,
    input  logic [31:0] r0_addr_i,
    input  logic        r0_we_i,
    input  logic [3:0]  r0_be_i,
    input  logic [31:0] r0_wdata_i,
    output logic        r0_gnt_o,
    output logic        r0_rvalid_o,
    output logic [31:0] r0_rdata_o,
    output logic        r0_err_o,

    input  logic        r1_req_i,
    input  logic [31:0] r1_addr_i,
    input  logic        r1_we_i,
    input  logic [3:0]  r1_be_i,
    input  logic [31:0] r1_wdata_i,
    output logic        r1_gnt_o,
    output logic        r1_rvalid_o,
    output logic [31:0] r1_rdata_o,
    output logic        r1_err_o,

    input  logic        clear_i,
    output logic        busy_o,

    output logic        mem_clkb,
    output logic        mem_enb,
    output logic        mem_rstb,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_addrb,
    output logic [31:0] mem_dinb,
    input  logic [31:0] mem_doutb,
    input  logic        mem_rstb_busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // 33-bit bounds so a window ending past 32'hFFFFFFFF cannot wrap
    localparam logic [32:0] c_addr_lo = {1'b0, ADDR_BASE};
    localparam logic [32:0] c_addr_hi = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_busy;
    logic        r_rvalid0;
    logic        r_rvalid1;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_din;

    logic        w_can_grant;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_in_range;
    logic        w_issue;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_be;
    logic        w_sel_we;

    assign w_can_grant = !reset && (r_state == IDLE) && !mem_rstb_busy && !clear_i;

`ifdef ARB_ROUND_ROBIN_EN
    // r_ptr = 1 favours r1 on the next contended cycle
    logic r_ptr;

    assign w_gnt0 = w_can_grant && r0_req_i && (!r1_req_i || !r_ptr);
    assign w_gnt1 = w_can_grant && r1_req_i && (!r0_req_i ||  r_ptr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (r0_req_i && r1_req_i && (w_gnt0 || w_gnt1)) begin
            r_ptr <= w_gnt0;
        end
    end
`else
    assign w_gnt0 = w_can_grant && r0_req_i;
    assign w_gnt1 = w_can_grant && r1_req_i && !r0_req_i;
`endif

    assign w_any_gnt   = w_gnt0 || w_gnt1;
    assign w_sel_addr  = w_gnt1 ? r1_addr_i  : r0_addr_i;
    assign w_sel_wdata = w_gnt1 ? r1_wdata_i : r0_wdata_i;
    assign w_sel_be    = w_gnt1 ? r1_be_i    : r0_be_i;
    assign w_sel_we    = w_gnt1 ? r1_we_i    : r0_we_i;

    assign w_in_range  = ({1'b0, w_sel_addr} >= c_addr_lo) &&
                         ({1'b0, w_sel_addr} <  c_addr_hi);
    assign w_issue     = w_any_gnt && w_in_range;

    assign r0_gnt_o  = w_gnt0;
    assign r1_gnt_o  = w_gnt1;

    assign mem_clkb  = clk;
    assign mem_enb   = w_issue;
    assign mem_web   = (w_issue && w_sel_we) ? w_sel_be : 4'b0000;
    assign mem_addrb = w_issue ? w_sel_addr  : r_addr;
    assign mem_dinb  = w_issue ? w_sel_wdata : r_din;
    assign mem_rstb  = r_busy;
    assign busy_o    = r_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 8'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_i) begin
                        r_state <= CLEAR;
                        r_count <= CLEAR_CYCLES - 8'd1;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_count == 8'd0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= 32'd0;
            r_din     <= 32'd0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            r_err     <= w_any_gnt && !w_in_range;
            if (w_issue) begin
                r_addr <= w_sel_addr;
                r_din  <= w_sel_wdata;
            end
        end
    end

    // Masking with reset drops a response that falls due while reset is held
    assign r0_rvalid_o = r_rvalid0 && !reset;
    assign r1_rvalid_o = r_rvalid1 && !reset;
    assign r0_err_o    = r0_rvalid_o && r_err;
    assign r1_err_o    = r1_rvalid_o && r_err;
    assign r0_rdata_o  = (r0_rvalid_o && !r_err) ? mem_doutb : 32'd0;
    assign r1_rdata_o  = (r1_rvalid_o && !r_err) ? mem_doutb : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Directed vector bench for bram_port_arbiter with a BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_be;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_be;
    logic        clear, busy;
    logic        mem_clkb, mem_enb, mem_rstb, mem_rstb_busy;
    logic [3:0]  mem_web;
    logic [31:0] mem_addrb, mem_dinb, mem_doutb;

    int n_applied = 0;
    int n_miss    = 0;

    always #5 clk = ~clk;

    bram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_we_i(r0_we), .r0_be_i(r0_be),
        .r0_wdata_i(r0_wdata), .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid),
        .r0_rdata_o(r0_rdata), .r0_err_o(r0_err),
        .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_we_i(r1_we), .r1_be_i(r1_be),
        .r1_wdata_i(r1_wdata), .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid),
        .r1_rdata_o(r1_rdata), .r1_err_o(r1_err),
        .clear_i(clear), .busy_o(busy),
        .mem_clkb(mem_clkb), .mem_enb(mem_enb), .mem_rstb(mem_rstb), .mem_web(mem_web),
        .mem_addrb(mem_addrb), .mem_dinb(mem_dinb), .mem_doutb(mem_doutb),
        .mem_rstb_busy(mem_rstb_busy)
    );

    // BRAM model: write-first, 1-cycle read latency, rstb zeroes the output
    logic [31:0] mem [0:8191];
    always @(posedge mem_clkb) begin
        logic [31:0] off;
        off = mem_addrb - 32'h600;
        if (mem_rstb) begin
            mem_doutb <= 32'd0;
        end else if (mem_enb) begin
            for (int b = 0; b < 4; b++)
                if (mem_web[b]) mem[off[14:2]][8*b +: 8] = mem_dinb[8*b +: 8];
            mem_doutb <= mem[off[14:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        r0_req = 0; r0_we = 0; r0_be = 0; r0_wdata = 0; r0_addr = 0;
        r1_req = 0; r1_we = 0; r1_be = 0; r1_wdata = 0; r1_addr = 0;
        clear = 0; mem_rstb_busy = 0;
    endtask

    typedef struct {
        logic        req0; logic [31:0] addr0; logic we0; logic [3:0] be0; logic [31:0] wd0;
        logic        req1; logic [31:0] addr1; logic we1; logic [3:0] be1; logic [31:0] wd1;
        logic        rbusy;
        logic        e_gnt0, e_gnt1, e_enb; logic [3:0] e_web; logic [31:0] e_addr;
        logic        e_rv0, e_rv1, e_err; logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rr;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int i = 0; i < 8192; i++) mem[i] = 32'd0;
        mem[0] = 32'hDEADBEEF;

        //            req0 addr0         we be     wd0           req1 addr1        we be     wd1          bsy g0 g1   en web     addr          rv0 rv1  err rdata
        vecs[0]  = '{1, 32'h600,  0, 4'h0, 32'h0,        0, 32'h0,    0, 4'h0, 32'h0,       0, 1, 0,   1, 4'h0, 32'h600,  1, 0,   0, 32'hDEADBEEF};
        vecs[1]  = '{0, 32'h0,    0, 4'h0, 32'h0,        1, 32'h604,  1, 4'h2, 32'h0000AB00,0, 0, 1,   1, 4'h2, 32'h604,  0, 1,   0, 32'h0000AB00};
        vecs[2]  = '{1, 32'h604,  0, 4'h0, 32'h0,        0, 32'h0,    0, 4'h0, 32'h0,       0, 1, 0,   1, 4'h0, 32'h604,  1, 0,   0, 32'h0000AB00};
        vecs[3]  = '{1, 32'h5FC,  0, 4'h0, 32'h0,        0, 32'h0,    0, 4'h0, 32'h0,       0, 1, 0,   0, 4'h0, 32'h604,  1, 0,   1, 32'h0};
        vecs[4]  = '{0, 32'h0,    0, 4'h0, 32'h0,        1, 32'h6E00, 0, 4'h0, 32'h0,       0, 0, 1,   0, 4'h0, 32'h604,  0, 1,   1, 32'h0};
        vecs[5]  = '{0, 32'h0,    0, 4'h0, 32'h0,        1, 32'h6DFC, 0, 4'h0, 32'h0,       0, 0, 1,   1, 4'h0, 32'h6DFC, 0, 1,   0, 32'h0};
        vecs[6]  = '{1, 32'h604,  0, 4'h0, 32'h0,        1, 32'h604,  0, 4'h0, 32'h0,       0, 1, 0,   1, 4'h0, 32'h604,  1, 0,   0, 32'h0000AB00};
        vecs[7]  = '{1, 32'h600,  0, 4'h0, 32'h0,        1, 32'h600,  0, 4'h0, 32'h0,       0, !rr, rr, 1, 4'h0, 32'h600, !rr, rr, 0, 32'hDEADBEEF};
        vecs[8]  = '{1, 32'h608,  1, 4'hF, 32'h11111111, 0, 32'h0,    0, 4'h0, 32'h0,       1, 0, 0,   0, 4'h0, 32'h600,  0, 0,   0, 32'h0};
        vecs[9]  = '{1, 32'h608,  1, 4'hF, 32'h12345678, 0, 32'h0,    0, 4'h0, 32'h0,       0, 1, 0,   1, 4'hF, 32'h608,  1, 0,   0, 32'h12345678};
        vecs[10] = '{0, 32'h0,    0, 4'h0, 32'h0,        1, 32'h608,  0, 4'h0, 32'h0,       0, 0, 1,   1, 4'h0, 32'h608,  0, 1,   0, 32'h12345678};

        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("reset_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_mem_rstb",  32'(mem_rstb),  32'd0);
        chk("reset_mem_enb",   32'(mem_enb),   32'd0);
        chk("reset_r0_rdata",  r0_rdata,       32'd0);
        reset = 0;

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            r0_req = vecs[v].req0; r0_addr = vecs[v].addr0; r0_we = vecs[v].we0;
            r0_be = vecs[v].be0; r0_wdata = vecs[v].wd0;
            r1_req = vecs[v].req1; r1_addr = vecs[v].addr1; r1_we = vecs[v].we1;
            r1_be = vecs[v].be1; r1_wdata = vecs[v].wd1;
            mem_rstb_busy = vecs[v].rbusy;
            #1;
            chk($sformatf("v%0d_gnt0", v),  32'(r0_gnt),  32'(vecs[v].e_gnt0));
            chk($sformatf("v%0d_gnt1", v),  32'(r1_gnt),  32'(vecs[v].e_gnt1));
            chk($sformatf("v%0d_enb", v),   32'(mem_enb), 32'(vecs[v].e_enb));
            chk($sformatf("v%0d_web", v),   32'(mem_web), 32'(vecs[v].e_web));
            chk($sformatf("v%0d_addrb", v), mem_addrb,    vecs[v].e_addr);
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            chk($sformatf("v%0d_rvalid0", v), 32'(r0_rvalid), 32'(vecs[v].e_rv0));
            chk($sformatf("v%0d_rvalid1", v), 32'(r1_rvalid), 32'(vecs[v].e_rv1));
            if (vecs[v].e_rv0) begin
                chk($sformatf("v%0d_err0", v),   32'(r0_err), 32'(vecs[v].e_err));
                chk($sformatf("v%0d_rdata0", v), r0_rdata,    vecs[v].e_rdata);
            end
            if (vecs[v].e_rv1) begin
                chk($sformatf("v%0d_err1", v),   32'(r1_err), 32'(vecs[v].e_err));
                chk($sformatf("v%0d_rdata1", v), r1_rdata,    vecs[v].e_rdata);
            end
        end

        // Contention: both requesters hold req for 8 cycles after a fresh reset
        begin
            int g0, g1;
            logic prev0, exp0;
            g0 = 0; g1 = 0; prev0 = 0;
            @(negedge clk); reset = 1;
            @(negedge clk); reset = 0;
            r0_req = 1; r0_addr = 32'h600; r1_req = 1; r1_addr = 32'h600;
            for (int i = 0; i < 8; i++) begin
                #1;
                exp0 = rr ? (i % 2 == 0) : 1'b1;
                chk($sformatf("cont%0d_gnt0", i), 32'(r0_gnt), 32'(exp0));
                chk($sformatf("cont%0d_gnt1", i), 32'(r1_gnt), 32'(!exp0));
                if (i > 0) chk($sformatf("cont%0d_rvalid0", i), 32'(r0_rvalid), 32'(prev0));
                g0 += int'(r0_gnt); g1 += int'(r1_gnt);
                prev0 = exp0;
                @(negedge clk);
            end
            idle_inputs();
            chk("cont_count_r0", 32'(g0), rr ? 32'd4 : 32'd8);
            chk("cont_count_r1", 32'(g1), rr ? 32'd4 : 32'd0);
        end

        // Clear: a grant just before clear_i completes; clear lasts CLEAR_CYCLES
        @(negedge clk);
        r0_req = 1; r0_addr = 32'h600;
        #1 chk("clr_pre_gnt0", 32'(r0_gnt), 32'd1);
        @(posedge clk); #1;
        clear = 1;
        #1;
        chk("clr_pre_rvalid0", 32'(r0_rvalid), 32'd1);
        chk("clr_pre_rdata0",  r0_rdata,       32'hDEADBEEF);
        chk("clr_cycle_gnt0",  32'(r0_gnt),    32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            clear = (i == 1);
            #1;
            chk($sformatf("clr%0d_busy", i), 32'(busy),     32'(i < 4));
            chk($sformatf("clr%0d_rstb", i), 32'(mem_rstb), 32'(i < 4));
            chk($sformatf("clr%0d_gnt0", i), 32'(r0_gnt),   32'(i == 4));
            @(posedge clk); #1;
        end
        idle_inputs();
        #1 chk("clr_post_rvalid0", 32'(r0_rvalid), 32'd1);

        // Reset the cycle after a grant: the pending response is dropped
        @(negedge clk);
        r0_req = 1; r0_addr = 32'h600;
        #1 chk("rst_gnt0", 32'(r0_gnt), 32'd1);
        @(posedge clk); #1;
        r0_req = 0; reset = 1;
        #1;
        chk("rst_rvalid0", 32'(r0_rvalid), 32'd0);
        chk("rst_err0",    32'(r0_err),    32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_enb",     32'(mem_enb),   32'd0);
        @(posedge clk); #1;
        reset = 0;
        #1 chk("rst_after_rvalid0", 32'(r0_rvalid), 32'd0);
        @(negedge clk);
        r0_req = 1; r0_addr = 32'h604;
        #1 chk("rst_next_gnt0", 32'(r0_gnt), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("rst_next_rvalid0", 32'(r0_rvalid), 32'd1);
        chk("rst_next_rdata0",  r0_rdata,       32'h0000AB00);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
